// File: rtl/cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clock_ctrl
// Purpose  : Run/halt/single-step clock controller. Divides inp_clk by a
//            programmable ratio and issues one-cycle clk_en pulses to the core.
// Revision : 1.0
// ============================================================================
module cpu_clock_ctrl #(
    parameter int DIV_W       = 8,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             inp_clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             clk_en,
    output logic             out_clk,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    state_t             state_q,     state_d;
    logic [DIV_W-1:0]   div_q,       div_d;
    logic [DIV_W-1:0]   pre_q,       pre_d;
    logic               clk_en_q,    clk_en_d;
    logic               out_clk_q,   out_clk_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;

    logic [DIV_W-1:0]   d_eff;
    logic [DIV_W-1:0]   d_last;
    logic               tick_due;
    logic               pulse;

    always_comb begin
        d_eff    = (div_q == '0) ? DIV_W'(1) : div_q;
        d_last   = d_eff - DIV_W'(1);
        // A configuration write always wins over a pending tick.
        tick_due = (state_q != ST_HALT) && (pre_q == d_last) && !cfg_we;

        state_d = state_q;
        pulse   = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (halt_req)      state_d = ST_HALT;
                else if (run_req)  state_d = ST_RUN;
                else if (step_req) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (halt_req) state_d = ST_HALT;
                else          pulse   = tick_due;
            end
            ST_STEP: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (run_req) begin
                    state_d = ST_RUN;
                    pulse   = tick_due;
                end else if (tick_due) begin
                    state_d = ST_HALT;
                    pulse   = 1'b1;
                end
            end
            default: state_d = ST_HALT;
        endcase

        div_d = cfg_we ? cfg_div : div_q;

        // Prescaler is parked at zero whenever halted or entering HALT, so a
        // restart always sees a full D-cycle interval.
        if (cfg_we || state_q == ST_HALT || state_d == ST_HALT)
            pre_d = '0;
        else if (pre_q == d_last)
            pre_d = '0;
        else
            pre_d = pre_q + DIV_W'(1);

        clk_en_d    = pulse;
        out_clk_d   = out_clk_q ^ pulse;
        cycle_cnt_d = cycle_cnt_q + CNT_W'(pulse);
    end

    always_ff @(posedge inp_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HALT;
            div_q       <= DIV_W'(DEFAULT_DIV);
            pre_q       <= '0;
            clk_en_q    <= 1'b0;
            out_clk_q   <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            pre_q       <= pre_d;
            clk_en_q    <= clk_en_d;
            out_clk_q   <= out_clk_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign clk_en    = clk_en_q;
    assign out_clk   = out_clk_q;
    assign state     = state_q;
    assign halted    = (state_q == ST_HALT);
    assign cycle_cnt = cycle_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_clock_ctrl
// Purpose  : Directed self-checking bench for cpu_clock_ctrl (32- and 4-bit
//            counter instances driven in lockstep).
// Revision : 1.0
// ============================================================================
module tb_cpu_clock_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_req, halt_req, step_req, cfg_we;
    logic [7:0]  cfg_div;

    logic        clk_en,  out_clk,  halted;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic        clk_en4, out_clk4, halted4;
    logic [1:0]  state4;
    logic [3:0]  cycle_cnt4;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned exp_cnt = 0;
    logic        seen;

    always #5 clk = ~clk;

    cpu_clock_ctrl #(.DIV_W(8), .CNT_W(32), .DEFAULT_DIV(2)) dut (
        .inp_clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .cfg_we(cfg_we), .cfg_div(cfg_div),
        .clk_en(clk_en), .out_clk(out_clk), .state(state), .halted(halted),
        .cycle_cnt(cycle_cnt)
    );

    cpu_clock_ctrl #(.DIV_W(8), .CNT_W(4), .DEFAULT_DIV(2)) dut4 (
        .inp_clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .cfg_we(cfg_we), .cfg_div(cfg_div),
        .clk_en(clk_en4), .out_clk(out_clk4), .state(state4), .halted(halted4),
        .cycle_cnt(cycle_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cnt32"}, cycle_cnt, exp_cnt);
        chk({tag, "_cnt4"}, 32'(cycle_cnt4), exp_cnt % 16);
    endtask

    task automatic nx(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        cfg_we = 1'b0; cfg_div = 8'd0;
        nx(2);
        chk("rst_clk_en", 32'(clk_en), 0);
        chk("rst_out_clk", 32'(out_clk), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_halted", 32'(halted), 1);
        chk_cnt("rst");
        rst = 1'b0;
        nx(1);

        // Test 1: default ratio 2 free run
        run_req = 1'b1; nx(1); run_req = 1'b0;
        chk("t1_state", 32'(state), 1);
        for (int i = 1; i <= 20; i++) begin
            nx(1);
            chk("t1_clk_en", 32'(clk_en), 32'(i % 2 == 0));
            chk("t1_out_clk", 32'(out_clk), (i / 2) % 2);
        end
        exp_cnt = 10;
        chk_cnt("t1");
        halt_req = 1'b1; nx(1); halt_req = 1'b0;
        chk("t1_halted", 32'(halted), 1);
        chk("t1_halt_clk_en", 32'(clk_en), 0);

        // Test 2: single step with D=3
        cfg_we = 1'b1; cfg_div = 8'd3; nx(1); cfg_we = 1'b0;
        step_req = 1'b1; nx(1); step_req = 1'b0;
        chk("t2_state_step", 32'(state), 2);
        nx(2);
        chk("t2_early_clk_en", 32'(clk_en), 0);
        nx(1);
        chk("t2_pulse", 32'(clk_en), 1);
        chk("t2_state_back", 32'(state), 0);
        chk("t2_out_clk", 32'(out_clk), 1);
        exp_cnt = 11;
        chk_cnt("t2");
        seen = 1'b0;
        repeat (20) begin nx(1); if (clk_en) seen = 1'b1; end
        chk("t2_no_more", 32'(seen), 0);
        chk_cnt("t2_after");

        // Test 3: D=4, halt on a tick-due edge, restart
        cfg_we = 1'b1; cfg_div = 8'd4; nx(1); cfg_we = 1'b0;
        run_req = 1'b1; nx(1); run_req = 1'b0;
        nx(3);
        chk("t3_pre_clk_en", 32'(clk_en), 0);
        nx(1);
        chk("t3_first_pulse", 32'(clk_en), 1);
        exp_cnt = 12;
        nx(3);
        halt_req = 1'b1; nx(1); halt_req = 1'b0;
        chk("t3_halt_no_pulse", 32'(clk_en), 0);
        chk("t3_halted", 32'(halted), 1);
        chk_cnt("t3");
        nx(5);
        chk("t3_out_frozen", 32'(out_clk), 0);
        run_req = 1'b1; nx(1); run_req = 1'b0;
        seen = 1'b0;
        repeat (3) begin nx(1); if (clk_en) seen = 1'b1; end
        chk("t3_restart_gap", 32'(seen), 0);
        nx(1);
        chk("t3_restart_pulse", 32'(clk_en), 1);
        chk("t3_out_clk", 32'(out_clk), 1);
        exp_cnt = 13;
        chk_cnt("t3_restart");

        // Test 4: ratio 0 acts as 1, then ratio 5 written on a tick-due edge
        cfg_we = 1'b1; cfg_div = 8'd0; nx(1); cfg_we = 1'b0;
        chk("t4_we_no_pulse", 32'(clk_en), 0);
        for (int i = 1; i <= 4; i++) begin
            nx(1);
            exp_cnt++;
            chk("t4_cont_clk_en", 32'(clk_en), 1);
            chk("t4_out_clk", 32'(out_clk), exp_cnt % 2);
        end
        chk_cnt("t4_cont");
        cfg_we = 1'b1; cfg_div = 8'd5; nx(1); cfg_we = 1'b0;
        chk("t4_suppressed", 32'(clk_en), 0);
        chk_cnt("t4_suppressed");
        seen = 1'b0;
        repeat (4) begin nx(1); if (clk_en) seen = 1'b1; end
        chk("t4_gap5", 32'(seen), 0);
        nx(1);
        chk("t4_pulse5", 32'(clk_en), 1);
        exp_cnt = 18;
        chk_cnt("t4");

        // Test 5: request priority
        halt_req = 1'b1; nx(1); halt_req = 1'b0;
        chk("t5_halted", 32'(halted), 1);
        halt_req = 1'b1; run_req = 1'b1; step_req = 1'b1; nx(1);
        halt_req = 1'b0; run_req = 1'b0; step_req = 1'b0;
        chk("t5_all_req_halt", 32'(state), 0);
        run_req = 1'b1; step_req = 1'b1; nx(1);
        run_req = 1'b0; step_req = 1'b0;
        chk("t5_run_wins", 32'(state), 1);
        halt_req = 1'b1; nx(1); halt_req = 1'b0;
        chk("t5_back_halt", 32'(state), 0);
        chk_cnt("t5");

        // Test 6: step with D=5, then reset asynchronously mid-STEP
        step_req = 1'b1; nx(1); step_req = 1'b0;
        nx(4);
        chk("t6_step_gap", 32'(clk_en), 0);
        nx(1);
        chk("t6_step_pulse", 32'(clk_en), 1);
        chk("t6_out_clk", 32'(out_clk), 1);
        exp_cnt = 19;
        chk_cnt("t6_step");
        step_req = 1'b1; nx(1); step_req = 1'b0;
        nx(2);
        chk("t6_mid_step", 32'(state), 2);
        #2 rst = 1'b1;
        #1;
        exp_cnt = 0;
        chk("t6_arst_clk_en", 32'(clk_en), 0);
        chk("t6_arst_out_clk", 32'(out_clk), 0);
        chk("t6_arst_state", 32'(state), 0);
        chk("t6_arst_halted", 32'(halted), 1);
        chk_cnt("t6_arst");
        nx(3);
        chk("t6_held_clk_en", 32'(clk_en), 0);
        rst = 1'b0;

        // Counter wrap: 17 pulses at the default ratio
        run_req = 1'b1; nx(1); run_req = 1'b0;
        nx(34);
        chk("t6_wrap_clk_en", 32'(clk_en), 1);
        exp_cnt = 17;
        chk_cnt("t6_wrap");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
